xorshift32_checker: RTL and testbench

Receive-side checker for the 32-bit xorshift (13/17/5) pseudo-random stream produced by the team's generator blocks. It monitors a word stream and locks onto the sequence from any nonzero word. It then predicts each following word, flags mismatches, counts errors with saturation, and drops lock after repeated consecutive misses. It sits at the consuming end of a PRNG link, for example after a serializer or FIFO, as a self-checking data sink.

---
 rtl/xorshift32_checker.sv | 161 ++++++++++++++++
 tb/tb_xorshift32_checker.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/xorshift32_checker.sv
// ============================================================================
// Module      : xorshift32_checker
// Description : Locks onto a xorshift32 (13/17/5) word stream, then flywheels
//               the prediction, flags and counts mismatches, and drops lock
//               after ERR_LIMIT consecutive misses.
//               Optional macro: XORSHIFT_CHECK_FORMAL_EN compiles in assertions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xorshift32_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_LIMIT  = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [31:0]      expected
);

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  localparam logic [7:0]       c_lock_count = 8'(LOCK_COUNT);
  localparam logic [7:0]       c_err_limit  = 8'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] c_cnt_max    = {CNT_W{1'b1}};

  function automatic logic [31:0] f_next(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  state_t           r_state, w_state_n;
  logic [7:0]       r_match_run, w_match_run_n;
  logic [7:0]       r_miss_run, w_miss_run_n;
  logic             r_locked, w_locked_n;
  logic             r_err, w_err_n;
  logic [CNT_W-1:0] r_err_count, w_err_count_n;
  logic [31:0]      r_expected, w_expected_n;

  logic [7:0]       w_match_inc;
  logic [7:0]       w_miss_inc;
  logic             w_hit;

  assign w_match_inc = r_match_run + 8'd1;
  assign w_miss_inc  = r_miss_run + 8'd1;
  assign w_hit       = (din == r_expected);

  always_comb begin
    w_state_n     = r_state;
    w_match_run_n = r_match_run;
    w_miss_run_n  = r_miss_run;
    w_err_n       = 1'b0;
    w_err_count_n = r_err_count;
    w_expected_n  = r_expected;

    if (din_valid) begin
      case (r_state)
        S_HUNT: begin
          if (din != 32'd0) begin
            w_expected_n  = f_next(din);
            w_match_run_n = 8'd0;
            w_state_n     = S_VERIFY;
          end
        end
        S_VERIFY: begin
          w_expected_n = f_next(din);
          if (w_hit) begin
            w_match_run_n = w_match_inc;
            if (w_match_inc == c_lock_count) begin
              w_state_n    = S_LOCKED;
              w_miss_run_n = 8'd0;
            end
          end else begin
            w_match_run_n = 8'd0;
            if (din == 32'd0) begin
              w_state_n = S_HUNT;
            end
          end
        end
        S_LOCKED: begin
          // Flywheel: the prediction advances from itself, never from din.
          w_expected_n = f_next(r_expected);
          if (w_hit) begin
            w_miss_run_n = 8'd0;
          end else begin
            w_err_n      = 1'b1;
            w_miss_run_n = w_miss_inc;
            if (r_err_count != c_cnt_max) begin
              w_err_count_n = r_err_count + 1'b1;
            end
            if (w_miss_inc == c_err_limit) begin
              w_state_n = S_HUNT;
            end
          end
        end
        default: begin
          w_state_n = S_HUNT;
        end
      endcase
    end

    w_locked_n = (w_state_n == S_LOCKED);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_HUNT;
      r_match_run <= 8'd0;
      r_miss_run  <= 8'd0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_err_count <= '0;
      r_expected  <= 32'd0;
    end else begin
      r_state     <= w_state_n;
      r_match_run <= w_match_run_n;
      r_miss_run  <= w_miss_run_n;
      r_locked    <= w_locked_n;
      r_err       <= w_err_n;
      r_err_count <= w_err_count_n;
      r_expected  <= w_expected_n;
    end
  end

  assign locked    = r_locked;
  assign err       = r_err;
  assign err_count = r_err_count;
  assign expected  = r_expected;

`ifdef XORSHIFT_CHECK_FORMAL_EN
  a_locked_state: assert property (@(posedge clock) disable iff (reset)
    locked == (r_state == S_LOCKED));

  a_err_needs_lock: assert property (@(posedge clock) disable iff (reset)
    err |-> $past(locked));

  a_count_monotonic: assert property (@(posedge clock) disable iff (reset)
    !$past(reset) |-> (err_count >= $past(err_count)));

  always @(posedge clock) begin
    if (!reset) begin
      a_expected_nonzero: assert (r_state == S_HUNT || r_expected != 32'd0);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_xorshift32_checker.sv
// ============================================================================
// Module      : tb_xorshift32_checker
// Description : Scoreboard bench for xorshift32_checker (default and CNT_W=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xorshift32_checker;

  localparam int LOCK_COUNT = 4;
  localparam int ERR_LIMIT  = 3;

  logic        clock;
  logic        reset;
  logic [31:0] din;
  logic        din_valid;
  logic        locked, err, locked2, err2;
  logic [15:0] err_count;
  logic [1:0]  err_count2;
  logic [31:0] expected, expected2;

  xorshift32_checker #(.LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(16)) u_dut (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .locked(locked), .err(err), .err_count(err_count), .expected(expected)
  );

  xorshift32_checker #(.LOCK_COUNT(LOCK_COUNT), .ERR_LIMIT(ERR_LIMIT), .CNT_W(2)) u_dut_sat (
    .clock(clock), .reset(reset), .din(din), .din_valid(din_valid),
    .locked(locked2), .err(err2), .err_count(err_count2), .expected(expected2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        locked;
    logic        err;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
    logic [31:0] exp;
  } resp_t;

  resp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 = hunting, 1 = verifying, 2 = locked.
  int          m_mode, m_match, m_miss, m_cnt, m_cnt2;
  logic        m_err;
  logic [31:0] m_exp;
  logic [31:0] g;

  function automatic logic [31:0] nxt(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    return t ^ (t << 5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
  endtask

  task automatic m_step(input logic r, input logic v, input logic [31:0] d);
    logic hit;
    if (r) begin
      m_mode = 0; m_match = 0; m_miss = 0; m_cnt = 0; m_cnt2 = 0;
      m_err = 1'b0; m_exp = 32'd0;
    end else begin
      m_err = 1'b0;
      if (v) begin
        if (m_mode == 0) begin
          if (d != 0) begin m_exp = nxt(d); m_match = 0; m_mode = 1; end
        end else if (m_mode == 1) begin
          hit   = (d == m_exp);
          m_exp = nxt(d);
          if (hit) begin
            m_match++;
            if (m_match == LOCK_COUNT) begin m_mode = 2; m_miss = 0; end
          end else begin
            m_match = 0;
            if (d == 0) m_mode = 0;
          end
        end else begin
          hit   = (d == m_exp);
          m_exp = nxt(m_exp);
          if (hit) m_miss = 0;
          else begin
            m_err  = 1'b1;
            m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
            m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            m_miss++;
            if (m_miss == ERR_LIMIT) m_mode = 0;
          end
        end
      end
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [31:0] d);
    resp_t e;
    @(negedge clock);
    reset = r; din_valid = v; din = d;
    m_step(r, v, d);
    e.locked = (m_mode == 2);
    e.err    = m_err;
    e.cnt    = 16'(m_cnt);
    e.cnt2   = 2'(m_cnt2);
    e.exp    = m_exp;
    q.push_back(e);
  endtask

  task automatic send_gen(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b1, g);
      g = nxt(g);
    end
  endtask

  // Replace the current stream slot with a wrong word, keeping alignment.
  task automatic send_bad(input logic [31:0] d);
    drive(1'b0, 1'b1, d);
    g = nxt(g);
  endtask

  // Monitor: every clock the DUT presents a fresh set of registered outputs.
  initial begin
    resp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("locked",     {31'd0, locked},     {31'd0, e.locked});
        chk("err",        {31'd0, err},        {31'd0, e.err});
        chk("err_count",  {16'd0, err_count},  {16'd0, e.cnt});
        chk("expected",   expected,            e.exp);
        chk("err_count2", {30'd0, err_count2}, {30'd0, e.cnt2});
      end
    end
  end

  initial begin
    int r;
    reset = 1'b1; din_valid = 1'b0; din = 32'd0;
    m_step(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b0, 32'd0);
    drive(1'b1, 1'b1, 32'h1234);

    // Acquire from seed 1; known first predictions.
    g = 32'd1;
    send_gen(1);
    @(posedge clock); #2;
    chk("seed1_expected", expected, 32'h00042021);
    send_gen(1);
    @(posedge clock); #2;
    chk("seed2_expected", expected, 32'h04080601);
    send_gen(3);
    @(posedge clock); #2;
    chk("locked_after_5", {31'd0, locked}, 32'd1);
    send_gen(4);

    // Single corrupted word: flywheel keeps lock.
    send_bad(g ^ 32'h1);
    send_gen(4);
    drive(1'b0, 1'b0, 32'hdead_beef);
    send_gen(2);

    // Three consecutive misses drop lock.
    send_bad(g ^ 32'h8000_0000);
    send_bad(32'h5555_aaaa);
    send_bad(g + 32'd7);
    send_gen(2);

    // Zeros never seed; 1 enters verify.
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 32'd0);
    g = 32'd1;
    send_gen(8);
    send_bad(g ^ 32'h1);
    send_gen(3);

    // Reset mid-lock with valid high, then re-acquire.
    drive(1'b1, 1'b1, g);
    g = nxt(g);
    send_gen(10);

    // Randomized traffic.
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 199);
      if (r < 20)       drive(1'b0, 1'b0, $urandom);
      else if (r < 160) send_gen(1);
      else if (r < 176) send_bad(g ^ (32'd1 << $urandom_range(0, 31)));
      else if (r < 182) send_bad(32'd0);
      else if (r < 190) begin g = $urandom | 32'd1; send_gen(1); end
      else if (r < 198) send_bad($urandom);
      else              drive(1'b1, $urandom_range(0, 1) == 1, $urandom);
    end
    drive(1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clock);
    #3;
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
